// File: rtl/tmds_channel_encoder.sv
// Per-channel TMDS encoder: DVI 1.0 video coding plus fixed control, guard-band and TERC4 symbols.
// Define TMDS_TERC4_EN to include the data-island (TERC4) symbols; otherwise modes 3 and 4 emit control symbols.
module tmds_channel_encoder #(
  parameter int CN = 0
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [2:0] mode,
  input  logic [7:0] video_data,
  input  logic [1:0] control_data,
  input  logic [3:0] data_island_data,
  output logic [9:0] tmds_symbol
);

  localparam logic [2:0] MODE_CTRL  = 3'd0;
  localparam logic [2:0] MODE_VIDEO = 3'd1;
  localparam logic [2:0] MODE_VGB   = 3'd2;
  localparam logic [2:0] MODE_TERC4 = 3'd3;
  localparam logic [2:0] MODE_DGB   = 3'd4;
  localparam logic [9:0] CTRL_00    = 10'b1101010100;
  localparam logic [9:0] GB_CH1     = 10'b0100110011;
  localparam logic [9:0] VGB_CH02   = 10'b1011001100;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4_sym(input logic [3:0] t);
    case (t)
      4'd0:    return 10'b1010011100;
      4'd1:    return 10'b1001100011;
      4'd2:    return 10'b1011100100;
      4'd3:    return 10'b1011100010;
      4'd4:    return 10'b0101110001;
      4'd5:    return 10'b0100011110;
      4'd6:    return 10'b0110001110;
      4'd7:    return 10'b0100111100;
      4'd8:    return 10'b1011001100;
      4'd9:    return 10'b0100111001;
      4'd10:   return 10'b0110011100;
      4'd11:   return 10'b1011000110;
      4'd12:   return 10'b1010001110;
      4'd13:   return 10'b1001110001;
      4'd14:   return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction
`endif

  logic [3:0]        n1_d;
  logic              use_xnor;
  logic [8:0]        q_m_next;
  logic [8:0]        q_m;
  logic [2:0]        mode_s1;
  logic [1:0]        ctrl_s1;
  logic signed [4:0] cnt;
  logic [3:0]        n1_q;
  logic signed [5:0] diff;
  logic signed [5:0] cnt_ext;
  logic signed [5:0] sum;
  logic [9:0]        sym_next;
  logic signed [4:0] cnt_next;

  // Stage 1 combinational: transition-minimising XOR/XNOR chain
  always_comb begin
    n1_d     = ones8(video_data);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && (video_data[0] == 1'b0));
    q_m_next = 9'd0;
    q_m_next[0] = video_data[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor) begin
        q_m_next[i] = ~(q_m_next[i-1] ^ video_data[i]);
      end else begin
        q_m_next[i] = q_m_next[i-1] ^ video_data[i];
      end
    end
    q_m_next[8] = ~use_xnor;
  end

  // Stage 1 register: q_m with its side-band fields
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      q_m     <= 9'd0;
      mode_s1 <= MODE_CTRL;
      ctrl_s1 <= 2'b00;
    end else begin
      q_m     <= q_m_next;
      mode_s1 <= mode;
      ctrl_s1 <= control_data;
    end
  end

`ifdef TMDS_TERC4_EN
  logic [3:0] terc_s1;

  // Stage 1 register: TERC4 nibble
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      terc_s1 <= 4'd0;
    end else begin
      terc_s1 <= data_island_data;
    end
  end
`else
  logic unused_terc;
  assign unused_terc = ^data_island_data;
`endif

  // Stage 2 combinational: DC balancing and fixed-symbol selection
  always_comb begin
    n1_q     = ones8(q_m[7:0]);
    diff     = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
    cnt_ext  = {cnt[4], cnt};
    sum      = 6'sd0;
    sym_next = CTRL_00;
    cnt_next = 5'sd0;
    case (mode_s1)
      MODE_VIDEO: begin
        if ((cnt == 5'sd0) || (diff == 6'sd0)) begin
          sym_next = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
          sum      = q_m[8] ? (cnt_ext + diff) : (cnt_ext - diff);
        end else if ((!cnt[4] && (diff > 6'sd0)) || (cnt[4] && (diff < 6'sd0))) begin
          sym_next = {1'b1, q_m[8], ~q_m[7:0]};
          sum      = cnt_ext + (q_m[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
          sym_next = {1'b0, q_m[8], q_m[7:0]};
          sum      = cnt_ext + diff - (q_m[8] ? 6'sd0 : 6'sd2);
        end
        cnt_next = sum[4:0];
      end
      MODE_VGB: sym_next = (CN == 1) ? GB_CH1 : VGB_CH02;
`ifdef TMDS_TERC4_EN
      MODE_TERC4: sym_next = terc4_sym(terc_s1);
      MODE_DGB:   sym_next = (CN == 0) ? terc4_sym({2'b11, ctrl_s1}) : GB_CH1;
`endif
      default: sym_next = ctrl_sym(ctrl_s1);
    endcase
  end

  // Stage 2 register: output symbol and running disparity
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      tmds_symbol <= CTRL_00;
      cnt         <= 5'sd0;
    end else begin
      tmds_symbol <= sym_next;
      cnt         <= cnt_next;
    end
  end

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Randomised self-checking bench for tmds_channel_encoder: three channels against a symbol-level model.
module tb_tmds_channel_encoder;

  logic       clk_pixel = 1'b0;
  logic       reset_n;
  logic [2:0] mode;
  logic [7:0] video_data;
  logic [1:0] control_data;
  logic [3:0] data_island_data;
  logic [9:0] sym0, sym1, sym2;

  int checks = 0;
  int failures = 0;

  always #5 clk_pixel = ~clk_pixel;

  tmds_channel_encoder #(.CN(0)) dut0 (.clk_pixel(clk_pixel), .reset_n(reset_n), .mode(mode),
    .video_data(video_data), .control_data(control_data), .data_island_data(data_island_data), .tmds_symbol(sym0));
  tmds_channel_encoder #(.CN(1)) dut1 (.clk_pixel(clk_pixel), .reset_n(reset_n), .mode(mode),
    .video_data(video_data), .control_data(control_data), .data_island_data(data_island_data), .tmds_symbol(sym1));
  tmds_channel_encoder #(.CN(2)) dut2 (.clk_pixel(clk_pixel), .reset_n(reset_n), .mode(mode),
    .video_data(video_data), .control_data(control_data), .data_island_data(data_island_data), .tmds_symbol(sym2));

  localparam logic [9:0] CTRL_TAB [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  localparam logic [9:0] TERC_TAB [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  // ---------------- reference model ----------------
  function automatic int disparity(input logic [9:0] s);
    return 2 * $countones(s) - 10;
  endfunction

  function automatic logic [9:0] video_model(input logic [7:0] d, input int cnt);
    int n, qn;
    bit xn;
    logic [8:0] q;
    n  = $countones(d);
    xn = (n > 4) || (n == 4 && d[0] == 1'b0);
    q  = 9'd0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !xn;
    qn = $countones(q[7:0]);
    if (cnt == 0 || qn == 4) return q[8] ? {2'b01, q[7:0]} : {2'b10, ~q[7:0]};
    if ((cnt > 0 && qn > 4) || (cnt < 0 && qn < 4)) return {1'b1, q[8], ~q[7:0]};
    return {1'b0, q[8], q[7:0]};
  endfunction

  function automatic logic [9:0] model_sym(input int cn, input logic [2:0] m, input logic [7:0] v,
                                           input logic [1:0] c, input logic [3:0] t, input int cnt);
    case (m)
      3'd1: return video_model(v, cnt);
      3'd2: return (cn == 1) ? 10'b0100110011 : 10'b1011001100;
`ifdef TMDS_TERC4_EN
      3'd3: return TERC_TAB[t];
      3'd4: return (cn == 0) ? TERC_TAB[{2'b11, c}] : 10'b0100110011;
`endif
      default: return CTRL_TAB[c];
    endcase
  endfunction

  task automatic check_sym(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] sym_of(input int ch);
    return (ch == 0) ? sym0 : ((ch == 1) ? sym1 : sym2);
  endfunction

  // ---------------- per-cycle compare process ----------------
  int         mcnt [3];
  logic [2:0] p_mode;
  logic [7:0] p_video;
  logic [1:0] p_ctrl;
  logic [3:0] p_terc;
  logic [9:0] cp_exp [3];
  bit         win_en = 1'b0;
  int         win_q[$];

  always @(posedge clk_pixel) begin
    if (!reset_n) begin
      for (int ch = 0; ch < 3; ch++) begin
        cp_exp[ch] = CTRL_TAB[0];
        mcnt[ch] = 0;
      end
      p_mode = 3'd0; p_ctrl = 2'b00; p_video = 8'd0; p_terc = 4'd0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        cp_exp[ch] = model_sym(ch, p_mode, p_video, p_ctrl, p_terc, mcnt[ch]);
        mcnt[ch] = (p_mode == 3'd1) ? mcnt[ch] + disparity(cp_exp[ch]) : 0;
      end
      p_mode = mode; p_video = video_data; p_ctrl = control_data; p_terc = data_island_data;
    end
    #1;
    check_sym("model_ch0", sym0, cp_exp[0]);
    check_sym("model_ch1", sym1, cp_exp[1]);
    check_sym("model_ch2", sym2, cp_exp[2]);
    check_int("model_cnt", int'(dut0.cnt), mcnt[0]);
    if (win_en) begin
      int s;
      checks++;
      if (int'(dut0.cnt) > 8 || int'(dut0.cnt) < -8) begin
        failures++;
        $display("FAIL cnt_bound: got %0d expected within -8..8", int'(dut0.cnt));
      end
      win_q.push_back(disparity(sym0));
      if (win_q.size() > 20) void'(win_q.pop_front());
      if (win_q.size() == 20) begin
        s = 0;
        foreach (win_q[i]) s += win_q[i];
        checks++;
        if (s > 20 || s < -20) begin
          failures++;
          $display("FAIL window20: got %0d expected |x|<=20", s);
        end
      end
    end
  end

  // ---------------- directed step helper (literal expectations, 2-cycle latency) ----------------
  bit         q_en[$];
  int         q_ch[$];
  logic [9:0] q_lit[$];
  bit         q_cen[$];
  int         q_cnt[$];
  string      q_name[$];

  task automatic clear_pipe();
    q_en.delete(); q_ch.delete(); q_lit.delete(); q_cen.delete(); q_cnt.delete(); q_name.delete();
  endtask

  task automatic step(input logic [2:0] m, input logic [7:0] v, input logic [1:0] c, input logic [3:0] t,
                      input bit en, input int ch, input logic [9:0] lit, input bit cen, input int lcnt,
                      input string name);
    @(negedge clk_pixel);
    if (q_en.size() == 2) begin
      bit e, ce; int h, lc; logic [9:0] l; string nm;
      e = q_en.pop_front(); h = q_ch.pop_front(); l = q_lit.pop_front();
      ce = q_cen.pop_front(); lc = q_cnt.pop_front(); nm = q_name.pop_front();
      if (e) check_sym(nm, sym_of(h), l);
      if (ce) check_int({nm, "_cnt"}, int'(dut0.cnt), lc);
    end
    mode = m; video_data = v; control_data = c; data_island_data = t;
    q_en.push_back(en); q_ch.push_back(ch); q_lit.push_back(lit);
    q_cen.push_back(cen); q_cnt.push_back(lcnt); q_name.push_back(name);
  endtask

  task automatic idle();
    step(3'd0, 8'd0, 2'b00, 4'd0, 1'b0, 0, 10'd0, 1'b0, 0, "idle");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] exp_m3, exp_m4c0, exp_m4c1;
    reset_n = 1'b0; mode = 3'd1; video_data = 8'h00; control_data = 2'b11; data_island_data = 4'd0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk_pixel);
      mode = 3'($urandom_range(0, 7)); video_data = 8'($urandom);
      control_data = 2'($urandom); data_island_data = 4'($urandom);
      check_sym("reset_ch0", sym0, 10'b1101010100);
      check_sym("reset_ch1", sym1, 10'b1101010100);
      check_int("reset_cnt", int'(dut0.cnt), 0);
    end

    @(negedge clk_pixel);
    reset_n = 1'b1; mode = 3'd1; video_data = 8'hFF;
    #1 check_sym("release0", sym0, 10'b1101010100);
    @(negedge clk_pixel);
    check_sym("release1", sym0, 10'b1101010100);
    mode = 3'd0; control_data = 2'b00;
    @(negedge clk_pixel);
    check_sym("first_ff", sym0, 10'b1000000000);
    check_int("first_ff_cnt", int'(dut0.cnt), -8);
    clear_pipe();

    for (int c = 0; c < 4; c++)
      step(3'd0, 8'd0, 2'(c), 4'd0, 1'b1, 0, CTRL_TAB[c], 1'b1, 0, $sformatf("ctrl%0d", c));
    step(3'd1, 8'h00, 2'b00, 4'd0, 1'b1, 0, 10'b0100000000, 1'b1, -8, "v00_a");
    step(3'd1, 8'h00, 2'b00, 4'd0, 1'b1, 0, 10'b1111111111, 1'b1, 2, "v00_b");
    step(3'd1, 8'h00, 2'b00, 4'd0, 1'b1, 0, 10'b0100000000, 1'b1, -6, "v00_c");
    idle();
    step(3'd1, 8'hFF, 2'b00, 4'd0, 1'b1, 0, 10'b1000000000, 1'b1, -8, "vff");
    step(3'd2, 8'h00, 2'b00, 4'd0, 1'b1, 1, 10'b0100110011, 1'b1, 0, "vgb_ch1");
    step(3'd2, 8'h00, 2'b00, 4'd0, 1'b1, 0, 10'b1011001100, 1'b1, 0, "vgb_ch0");
    for (int t = 0; t < 16; t++) begin
`ifdef TMDS_TERC4_EN
      exp_m3 = TERC_TAB[t];
`else
      exp_m3 = CTRL_TAB[1];
`endif
      step(3'd3, 8'h00, 2'b01, 4'(t), 1'b1, 0, exp_m3, 1'b0, 0, $sformatf("terc%0d", t));
    end
`ifdef TMDS_TERC4_EN
    exp_m4c0 = 10'b0101100011;
    exp_m4c1 = 10'b0100110011;
`else
    exp_m4c0 = 10'b0101010100;
    exp_m4c1 = 10'b0101010100;
`endif
    step(3'd4, 8'h00, 2'b10, 4'd0, 1'b1, 0, exp_m4c0, 1'b0, 0, "dgb_ch0");
    step(3'd4, 8'h00, 2'b10, 4'd0, 1'b1, 1, exp_m4c1, 1'b0, 0, "dgb_ch1");
    for (int m = 5; m < 8; m++)
      step(3'(m), 8'h5A, 2'b11, 4'd3, 1'b1, 2, 10'b1010101011, 1'b0, 0, $sformatf("mode%0d", m));
    idle();
    idle();

    for (int i = 0; i < 400; i++)
      step(3'($urandom_range(0, 7)), 8'($urandom), 2'($urandom), 4'($urandom), 1'b0, 0, 10'd0, 1'b0, 0, "rnd");

    step(3'd1, 8'($urandom), 2'b00, 4'd0, 1'b0, 0, 10'd0, 1'b0, 0, "vid");
    step(3'd1, 8'($urandom), 2'b00, 4'd0, 1'b0, 0, 10'd0, 1'b0, 0, "vid");
    win_q.delete();
    win_en = 1'b1;
    for (int i = 0; i < 10000; i++)
      step(3'd1, 8'($urandom), 2'b00, 4'd0, 1'b0, 0, 10'd0, 1'b0, 0, "vid");
    @(negedge clk_pixel);
    win_en = 1'b0;

    for (int i = 0; i < 5; i++)
      step(3'd1, 8'($urandom), 2'b00, 4'd0, 1'b0, 0, 10'd0, 1'b0, 0, "vid");
    @(posedge clk_pixel);
    #2 reset_n = 1'b0;
    #1 check_sym("async_rst_ch0", sym0, 10'b1101010100);
    check_sym("async_rst_ch2", sym2, 10'b1101010100);
    check_int("async_rst_cnt", int'(dut0.cnt), 0);
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    reset_n = 1'b1; mode = 3'd1; video_data = 8'($urandom);
    #1 check_int("post_rst_cnt", int'(dut0.cnt), 0);
    clear_pipe();
    for (int i = 0; i < 20; i++)
      step(3'd1, 8'($urandom), 2'b00, 4'd0, 1'b0, 0, 10'd0, 1'b0, 0, "vid");
    idle();
    idle();
    @(negedge clk_pixel);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
